// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole judge.
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SHOW = 3'd1,
    HIT  = 3'd2,
    MISS = 3'd3,
    OVER = 3'd4
  } state_t;

  localparam logic [3:0] NO_KEY  = 4'd0;
  localparam logic [3:0] POS_MIN = 4'd1;
  localparam logic [3:0] POS_MAX = 4'd9;

  localparam int SCORE_W = 8;
  localparam int ROUND_W = 8;
  localparam int MISS_W  = 3;
  localparam int TIMER_W = 4;

  // Anything outside the 3x3 keypad range lights the first cell.
  function automatic logic [3:0] clamp_pos(input logic [3:0] p);
    return ((p < POS_MIN) || (p > POS_MAX)) ? POS_MIN : p;
  endfunction

endpackage

// File: rtl/mole_judge.sv
// Game judge: latches mole targets, samples keypad once per tick, keeps score/misses/rounds; all outputs registered.
// No backpressure: inputs are sampled every clk_1hz edge. MOLE_STREAK_EN adds a 3-hit streak bonus and streak port.
module mole_judge
  import mole_pkg::*;
#(
  parameter int unsigned ROUNDS   = 20,
  parameter int unsigned WINDOW   = 2,
  parameter int unsigned MAX_MISS = 3
) (
  input  logic                 rst,
  input  logic                 clk_1hz,
  input  logic [3:0]           position,
  input  logic                 start,
  input  logic [3:0]           key_code,
  output logic [3:0]           target,
  output logic [SCORE_W-1:0]   score,
  output logic [MISS_W-1:0]    misses,
  output logic [ROUND_W-1:0]   round_cnt,
  output logic                 hit,
  output logic                 miss,
  output logic                 game_over
`ifdef MOLE_STREAK_EN
  ,
  output logic [1:0]           streak
`endif
);

  localparam logic [ROUND_W-1:0] ROUNDS_L   = ROUND_W'(ROUNDS);
  localparam logic [TIMER_W-1:0] WINDOW_L   = TIMER_W'(WINDOW);
  localparam logic [MISS_W-1:0]  MAX_MISS_L = MISS_W'(MAX_MISS);

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [3:0]           target_nxt;
  logic [SCORE_W-1:0]   score_nxt, score_sat;
  logic [MISS_W-1:0]    misses_nxt, misses_inc;
  logic [ROUND_W-1:0]   round_nxt, round_inc;
  logic                 hit_nxt, miss_nxt, over_nxt;
  logic                 key_hit, key_wrong, timed_out, end_game;
  logic [1:0]           hit_pts;
  logic [SCORE_W:0]     score_sum;

  // target is never 0 while in SHOW, so NO_KEY can never register as a hit.
  assign key_hit   = (key_code == target);
  assign key_wrong = (key_code != NO_KEY) && !key_hit;
  assign timed_out = (timer == TIMER_W'(1));

  assign score_sum  = {1'b0, score} + {{(SCORE_W-1){1'b0}}, hit_pts};
  assign score_sat  = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign misses_inc = (misses == {MISS_W{1'b1}}) ? misses : misses + MISS_W'(1);
  assign round_inc  = (round_cnt < ROUNDS_L) ? round_cnt + ROUND_W'(1) : round_cnt;
  assign end_game   = (round_cnt == ROUNDS_L) || (misses == MAX_MISS_L);

`ifdef MOLE_STREAK_EN
  logic [1:0] streak_nxt;

  assign hit_pts = (streak == 2'd2) ? 2'd2 : 2'd1;

  always_comb begin
    streak_nxt = streak;
    if (state == IDLE && start) begin
      streak_nxt = 2'd0;
    end else if (state == SHOW) begin
      if (key_hit)
        streak_nxt = (streak == 2'd2) ? 2'd0 : streak + 2'd1;
      else if (key_wrong || timed_out)
        streak_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) streak <= 2'd0;
    else      streak <= streak_nxt;
  end
`else
  assign hit_pts = 2'd1;
`endif

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    target_nxt = target;
    score_nxt  = score;
    misses_nxt = misses;
    round_nxt  = round_cnt;
    hit_nxt    = 1'b0;
    miss_nxt   = 1'b0;
    over_nxt   = 1'b0;
    case (state)
      IDLE: begin
        target_nxt = NO_KEY;
        if (start) begin
          state_nxt  = SHOW;
          target_nxt = clamp_pos(position);
          timer_nxt  = WINDOW_L;
          score_nxt  = '0;
          misses_nxt = '0;
          round_nxt  = '0;
        end
      end
      SHOW: begin
        if (key_hit) begin
          state_nxt  = HIT;
          target_nxt = NO_KEY;
          hit_nxt    = 1'b1;
          score_nxt  = score_sat;
          round_nxt  = round_inc;
        end else if (key_wrong || timed_out) begin
          state_nxt  = MISS;
          target_nxt = NO_KEY;
          miss_nxt   = 1'b1;
          misses_nxt = misses_inc;
          round_nxt  = round_inc;
        end else begin
          timer_nxt = timer - TIMER_W'(1);
        end
      end
      HIT, MISS: begin
        if (end_game) begin
          state_nxt  = OVER;
          target_nxt = NO_KEY;
          over_nxt   = 1'b1;
        end else begin
          state_nxt  = SHOW;
          target_nxt = clamp_pos(position);
          timer_nxt  = WINDOW_L;
        end
      end
      OVER: begin
        target_nxt = NO_KEY;
        over_nxt   = 1'b1;
        if (start) begin
          state_nxt = IDLE;
          over_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        target_nxt = NO_KEY;
      end
    endcase
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      target    <= NO_KEY;
      score     <= '0;
      misses    <= '0;
      round_cnt <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      target    <= target_nxt;
      score     <= score_nxt;
      misses    <= misses_nxt;
      round_cnt <= round_nxt;
      hit       <= hit_nxt;
      miss      <= miss_nxt;
      game_over <= over_nxt;
    end
  end

endmodule

// File: tb/tb_mole_judge.sv
// Directed bench for mole_judge with ROUNDS=4, WINDOW=2, MAX_MISS=3.
module tb_mole_judge;

  logic       rst = 1'b0;
  logic       clk_1hz = 1'b0;
  logic [3:0] position = 4'd0;
  logic       start = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] target;
  logic [7:0] score;
  logic [2:0] misses;
  logic [7:0] round_cnt;
  logic       hit, miss, game_over;
`ifdef MOLE_STREAK_EN
  logic [1:0] streak;
`endif

  int vectors = 0;
  int errors  = 0;

  mole_judge #(.ROUNDS(4), .WINDOW(2), .MAX_MISS(3)) u_dut (
    .rst       (rst),
    .clk_1hz   (clk_1hz),
    .position  (position),
    .start     (start),
    .key_code  (key_code),
    .target    (target),
    .score     (score),
    .misses    (misses),
    .round_cnt (round_cnt),
    .hit       (hit),
    .miss      (miss),
    .game_over (game_over)
`ifdef MOLE_STREAK_EN
    ,
    .streak    (streak)
`endif
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic tick();
    @(posedge clk_1hz);
    #1;
  endtask

  // Fresh game: pulse reset, then start with the given first position.
  task automatic new_game(input logic [3:0] pos);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    start = 1'b1;
    position = pos;
    key_code = 4'd0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    vectors++; if (target !== 4'd0)    begin errors++; $display("FAIL reset_target got %0d exp 0", target); end
    vectors++; if (score !== 8'd0)     begin errors++; $display("FAIL reset_score got %0d exp 0", score); end
    vectors++; if (misses !== 3'd0)    begin errors++; $display("FAIL reset_misses got %0d exp 0", misses); end
    vectors++; if (round_cnt !== 8'd0) begin errors++; $display("FAIL reset_round got %0d exp 0", round_cnt); end
    vectors++; if ({hit, miss, game_over} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {hit, miss, game_over}); end
`ifdef MOLE_STREAK_EN
    vectors++; if (streak !== 2'd0) begin errors++; $display("FAIL reset_streak got %0d exp 0", streak); end
`endif
    rst = 1'b1;
    position = 4'd6;
    tick();
    vectors++; if (target !== 4'd0) begin errors++; $display("FAIL idle_no_start_target got %0d exp 0", target); end
  endtask

  // Hit, wrong key, timeout, clamp, hit on timeout tick, then game over and restart.
  task automatic test_game_flow();
    new_game(4'd5);
    vectors++; if (target !== 4'd5) begin errors++; $display("FAIL show_target got %0d exp 5", target); end
    key_code = 4'd5;
    position = 4'd7;
    tick();
    vectors++; if (hit !== 1'b1)       begin errors++; $display("FAIL hit_flag got %0d exp 1", hit); end
    vectors++; if (score !== 8'd1)     begin errors++; $display("FAIL hit_score got %0d exp 1", score); end
    vectors++; if (round_cnt !== 8'd1) begin errors++; $display("FAIL hit_round got %0d exp 1", round_cnt); end
    vectors++; if (target !== 4'd0)    begin errors++; $display("FAIL hit_target got %0d exp 0", target); end
    tick();
    vectors++; if (hit !== 1'b0)    begin errors++; $display("FAIL hit_one_tick got %0d exp 0", hit); end
    vectors++; if (target !== 4'd7) begin errors++; $display("FAIL next_target got %0d exp 7", target); end
    key_code = 4'd3;
    tick();
    vectors++; if (miss !== 1'b1)   begin errors++; $display("FAIL wrong_miss got %0d exp 1", miss); end
    vectors++; if (misses !== 3'd1) begin errors++; $display("FAIL wrong_misses got %0d exp 1", misses); end
    vectors++; if (score !== 8'd1)  begin errors++; $display("FAIL wrong_score got %0d exp 1", score); end
    key_code = 4'd0;
    position = 4'd2;
    tick();
    vectors++; if (target !== 4'd2) begin errors++; $display("FAIL timeout_target got %0d exp 2", target); end
    tick();
    vectors++; if (miss !== 1'b0) begin errors++; $display("FAIL timeout_early got %0d exp 0", miss); end
    tick();
    vectors++; if (miss !== 1'b1)      begin errors++; $display("FAIL timeout_miss got %0d exp 1", miss); end
    vectors++; if (misses !== 3'd2)    begin errors++; $display("FAIL timeout_misses got %0d exp 2", misses); end
    vectors++; if (round_cnt !== 8'd3) begin errors++; $display("FAIL timeout_round got %0d exp 3", round_cnt); end
    position = 4'd0;
    tick();
    vectors++; if (target !== 4'd1) begin errors++; $display("FAIL clamp_target got %0d exp 1", target); end
    tick();
    key_code = 4'd1;
    tick();
    vectors++; if (hit !== 1'b1)   begin errors++; $display("FAIL late_hit got %0d exp 1", hit); end
    vectors++; if (score !== 8'd2) begin errors++; $display("FAIL late_score got %0d exp 2", score); end
    tick();
    vectors++; if (game_over !== 1'b1) begin errors++; $display("FAIL rounds_over got %0d exp 1", game_over); end
    vectors++; if (round_cnt !== 8'd4) begin errors++; $display("FAIL rounds_cnt got %0d exp 4", round_cnt); end
    tick();
    vectors++; if (score !== 8'd2 || game_over !== 1'b1) begin errors++; $display("FAIL over_frozen got %0d/%0d exp 2/1", score, game_over); end
    start = 1'b1;
    tick();
    vectors++; if (game_over !== 1'b0 || score !== 8'd2) begin errors++; $display("FAIL over_exit got %0d/%0d exp 0/2", game_over, score); end
    position = 4'd8;
    tick();
    start = 1'b0;
    vectors++; if ({score, round_cnt} !== 16'd0 || misses !== 3'd0) begin errors++; $display("FAIL restart_clear got %0d/%0d/%0d exp 0/0/0", score, round_cnt, misses); end
    vectors++; if (target !== 4'd8) begin errors++; $display("FAIL restart_target got %0d exp 8", target); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pos_t[4];
    logic [7:0] exp_sc[4];
`ifdef MOLE_STREAK_EN
    logic [1:0] exp_st[4];
    exp_st = '{2'd1, 2'd2, 2'd0, 2'd1};
    exp_sc = '{8'd1, 8'd2, 8'd4, 8'd5};
`else
    exp_sc = '{8'd1, 8'd2, 8'd3, 8'd4};
`endif
    pos_t = '{4'd3, 4'd3, 4'd8, 4'd1};
    new_game(pos_t[0]);
    for (int i = 0; i < 4; i++) begin
      key_code = pos_t[i];
      if (i < 3) position = pos_t[i+1];
      tick();
      vectors++; if (hit !== 1'b1 || score !== exp_sc[i]) begin errors++; $display("FAIL b2b_hit%0d got %0d/%0d exp 1/%0d", i, hit, score, exp_sc[i]); end
`ifdef MOLE_STREAK_EN
      vectors++; if (streak !== exp_st[i]) begin errors++; $display("FAIL b2b_streak%0d got %0d exp %0d", i, streak, exp_st[i]); end
`endif
      tick();
      if (i < 3) begin
        vectors++; if (target !== pos_t[i+1]) begin errors++; $display("FAIL b2b_target%0d got %0d exp %0d", i, target, pos_t[i+1]); end
      end else begin
        vectors++; if (game_over !== 1'b1 || score !== exp_sc[3]) begin errors++; $display("FAIL b2b_over got %0d/%0d exp 1/%0d", game_over, score, exp_sc[3]); end
      end
    end
    key_code = 4'd0;
  endtask

  task automatic test_max_miss();
    new_game(4'd4);
    position = 4'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      vectors++; if (miss !== 1'b1 || misses !== 3'(i + 1)) begin errors++; $display("FAIL maxmiss_%0d got %0d/%0d exp 1/%0d", i, miss, misses, i + 1); end
      tick();
      if (i < 2) begin
        vectors++; if (target !== 4'd6) begin errors++; $display("FAIL maxmiss_target%0d got %0d exp 6", i, target); end
      end
    end
    vectors++; if (game_over !== 1'b1)  begin errors++; $display("FAIL maxmiss_over got %0d exp 1", game_over); end
    vectors++; if (round_cnt !== 8'd3)  begin errors++; $display("FAIL maxmiss_round got %0d exp 3", round_cnt); end
  endtask

`ifdef MOLE_STREAK_EN
  task automatic test_streak_clear();
    new_game(4'd2);
    key_code = 4'd2;
    tick();
    tick();
    tick();
    vectors++; if (streak !== 2'd2 || score !== 8'd2) begin errors++; $display("FAIL streak_two got %0d/%0d exp 2/2", streak, score); end
    position = 4'd4;
    tick();
    key_code = 4'd9;
    tick();
    vectors++; if (miss !== 1'b1 || streak !== 2'd0 || score !== 8'd2) begin errors++; $display("FAIL streak_clear got %0d/%0d/%0d exp 1/0/2", miss, streak, score); end
    key_code = 4'd0;
  endtask
`endif

  task automatic test_async_reset();
    new_game(4'd5);
    key_code = 4'd5;
    tick();
    key_code = 4'd0;
    position = 4'd9;
    tick();
    vectors++; if (target !== 4'd9 || score !== 8'd1) begin errors++; $display("FAIL pre_reset got %0d/%0d exp 9/1", target, score); end
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (target !== 4'd0 || score !== 8'd0 || round_cnt !== 8'd0) begin errors++; $display("FAIL async_reset got %0d/%0d/%0d exp 0/0/0", target, score, round_cnt); end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_game_flow();
    test_back_to_back();
    test_max_miss();
`ifdef MOLE_STREAK_EN
    test_streak_clear();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
